// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - UART byte stream to validated command frame parser
// Optional FRAME_TIMEOUT_EN: abandon a partial frame after TIMEOUT_CYC idle clk cycles.
module uart_frame_parser #(
  parameter int          MAX_LEN     = 16,
  parameter int          ADDR_W      = 4,
  parameter logic [7:0]  HDR0        = 8'h55,
  parameter logic [7:0]  HDR1        = 8'hAA,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4340
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_finish,
  output logic              frame_ready,
  output logic [7:0]        frame_cmd,
  output logic [7:0]        frame_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              frame_ack,
  output logic              frame_err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_H0, S_H1, S_CMD, S_LEN, S_PAY, S_CSUM, S_HOLD
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [1:0] ERR_CSUM  = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_OVR   = 2'd3;

  state_t     state, state_next;
  logic [7:0] csum, csum_next;
  logic [7:0] count;
  logic [7:0] cmd_q;
  logic [7:0] len_q;
  logic       cmd_load, len_load;
  logic       count_clr, count_inc;
  logic       buf_we;
  logic       commit, release_frame;
  logic       err_set;
  logic [1:0] err_code_next;
  logic       tmo_expire;

  logic [7:0] pay_mem [DEPTH];

`ifdef FRAME_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_active;

  assign tmo_active = (state != S_H0) && (state != S_HOLD);
  // A byte arriving on the expiry cycle takes priority over the timeout
  assign tmo_expire = tmo_active && !rx_finish && (tmo_cnt == TIMEOUT_CYC);

  // Inter-byte idle counter, only running while a frame is partially received
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (rx_finish || !tmo_active || tmo_expire) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_H0;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decoded from byte events, ack and timeout
  always_comb begin
    state_next    = state;
    csum_next     = csum;
    cmd_load      = 1'b0;
    len_load      = 1'b0;
    count_clr     = 1'b0;
    count_inc     = 1'b0;
    buf_we        = 1'b0;
    commit        = 1'b0;
    release_frame = 1'b0;
    err_set       = 1'b0;
    err_code_next = err_code;
    if (rx_finish) begin
      case (state)
        S_H0: begin
          if (rx_data == HDR0) state_next = S_H1;
        end
        S_H1: begin
          if (rx_data == HDR1)      state_next = S_CMD;
          else if (rx_data == HDR0) state_next = S_H1;
          else                      state_next = S_H0;
        end
        S_CMD: begin
          cmd_load   = 1'b1;
          csum_next  = rx_data;
          state_next = S_LEN;
        end
        S_LEN: begin
          csum_next = csum + rx_data;
          if (rx_data > MAX_LEN_B) begin
            err_set       = 1'b1;
            err_code_next = ERR_LEN;
            state_next    = S_H0;
          end else begin
            // Length is latched even when zero so the committed frame_len is correct
            len_load   = 1'b1;
            count_clr  = 1'b1;
            state_next = (rx_data == 8'd0) ? S_CSUM : S_PAY;
          end
        end
        S_PAY: begin
          buf_we    = 1'b1;
          csum_next = csum + rx_data;
          count_inc = 1'b1;
          if ((count + 8'd1) == len_q) state_next = S_CSUM;
        end
        S_CSUM: begin
          if (rx_data == csum) begin
            commit     = 1'b1;
            state_next = S_HOLD;
          end else begin
            err_set       = 1'b1;
            err_code_next = ERR_CSUM;
            state_next    = S_H0;
          end
        end
        S_HOLD: begin
          if (frame_ack) begin
            // Ack wins: the byte is treated as the first byte of a new hunt
            release_frame = 1'b1;
            state_next    = (rx_data == HDR0) ? S_H1 : S_H0;
          end else begin
            err_set       = 1'b1;
            err_code_next = ERR_OVR;
          end
        end
        default: state_next = S_H0;
      endcase
    end else if ((state == S_HOLD) && frame_ack) begin
      release_frame = 1'b1;
      state_next    = S_H0;
    end else if (tmo_expire) begin
      err_set       = 1'b1;
      err_code_next = ERR_TMO;
      state_next    = S_H0;
    end
  end

  // Frame assembly registers and consumer-visible frame/error outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum        <= '0;
      count       <= '0;
      cmd_q       <= '0;
      len_q       <= '0;
      frame_ready <= 1'b0;
      frame_cmd   <= '0;
      frame_len   <= '0;
      frame_err   <= 1'b0;
      err_code    <= '0;
    end else begin
      csum <= csum_next;
      if (cmd_load) cmd_q <= rx_data;
      if (len_load) len_q <= rx_data;
      if (count_clr)      count <= '0;
      else if (count_inc) count <= count + 8'd1;
      if (commit) begin
        frame_ready <= 1'b1;
        frame_cmd   <= cmd_q;
        frame_len   <= len_q;
      end else if (release_frame) begin
        frame_ready <= 1'b0;
      end
      frame_err <= err_set;
      if (err_set) err_code <= err_code_next;
    end
  end

  // Payload buffer write; only reachable in S_PAY so a held frame is never overwritten
  always_ff @(posedge clk) begin
    if (buf_we) pay_mem[count[ADDR_W-1:0]] <= rx_data;
  end

  // Registered read port, one cycle of latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= pay_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         ADDR_W  = 4;
  localparam logic [7:0] HDR0    = 8'h55;
  localparam logic [7:0] HDR1    = 8'hAA;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_finish;
  logic              frame_ready;
  logic [7:0]        frame_cmd;
  logic [7:0]        frame_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_ack;
  logic              frame_err;
  logic [1:0]        err_code;

  uart_frame_parser #(
    .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .HDR0(HDR0), .HDR1(HDR1), .TIMEOUT_CYC(16'd4340)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_finish(rx_finish),
    .frame_ready(frame_ready), .frame_cmd(frame_cmd), .frame_len(frame_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_ack(frame_ack),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_strobe = 0;
  bit frame_checked = 1'b0;
  bit held = 1'b0;

  // expected-event scoreboard: kind 0 = frame commit, 1 = error pulse
  int         ev_kind[$];
  logic [1:0] ev_code[$];
  logic [7:0] ev_cmd[$];
  logic [7:0] ev_len[$];
  bit         ev_tchk[$];
  logic [7:0] pay_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_err(input logic [1:0] code, input bit tchk);
    ev_kind.push_back(1); ev_code.push_back(code);
    ev_cmd.push_back(8'd0); ev_len.push_back(8'd0); ev_tchk.push_back(tchk);
  endtask

  task automatic push_frame(input logic [7:0] cmd, input logic [7:0] len);
    ev_kind.push_back(0); ev_code.push_back(2'd0);
    ev_cmd.push_back(cmd); ev_len.push_back(len); ev_tchk.push_back(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack);
    @(negedge clk);
    rx_data = b; rx_finish = 1'b1; frame_ack = ack;
    last_strobe = cyc;
    @(negedge clk);
    rx_finish = 1'b0; frame_ack = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // mode 0 good, 1 corrupted checksum, 2 oversize length (len is the bad length)
  task automatic send_frame(input logic [7:0] cmd, input int len, input int mode,
                            input int resync, input bit ack_first, input bit fixed);
    logic [7:0] pay [0:255];
    int sum;
    send_byte(HDR0, ack_first);
    repeat (resync) send_byte(HDR0, 1'b0);
    send_byte(HDR1, 1'b0);
    send_byte(cmd, 1'b0);
    if (mode == 2) begin
      push_err(2'd1, 1'b1);
      send_byte(8'(len), 1'b0);
      return;
    end
    sum = int'(cmd) + len;
    for (int i = 0; i < len; i++) begin
      pay[i] = fixed ? 8'(i + 1) : 8'($urandom_range(0, 255));
      sum += int'(pay[i]);
    end
    send_byte(8'(len), 1'b0);
    for (int i = 0; i < len; i++) send_byte(pay[i], 1'b0);
    if (mode == 0) begin
      push_frame(cmd, 8'(len));
      for (int i = 0; i < len; i++) pay_q.push_back(pay[i]);
      frame_checked = 1'b0;
      send_byte(8'(sum % 256), 1'b0);
    end else begin
      push_err(2'd0, 1'b1);
      send_byte(8'((sum % 256) + $urandom_range(1, 255)), 1'b0);
    end
  endtask

  task automatic wait_checked();
    int n = 0;
    while (!frame_checked && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("frame_read_done", frame_checked, 1);
  endtask

  task automatic ack_plain();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("ack_release", frame_ready, 0);
    held = 1'b0;
  endtask

  task automatic overrun(input logic [7:0] b);
    push_err(2'd3, 1'b1);
    send_byte(b, 1'b0);
    wait_checked();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ready"}, frame_ready, 0);
    chk({tag, "_cmd"}, frame_cmd, 0);
    chk({tag, "_len"}, frame_len, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_code"}, err_code, 0);
  endtask

  // Monitor: pops expected events whenever the DUT presents a frame or an error pulse
  initial begin : monitor
    bit prev_ready;
    bit reading;
    bit rd_cmp;
    bit ok;
    int rd_n, rd_i, rd_cmp_idx;
    int k;
    logic [1:0] code;
    logic [7:0] ecmd, elen;
    bit tchk;
    logic [7:0] exp_pay [0:255];
    logic [7:0] held_cmd, held_len;
    prev_ready = 0; reading = 0; rd_cmp = 0; rd_n = 0; rd_i = 0; rd_cmp_idx = 0;
    held_cmd = 0; held_len = 0;
    rd_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready = 0; reading = 0; rd_cmp = 0;
        continue;
      end
      if (rd_cmp) begin
        chk("rd_data", rd_data, exp_pay[rd_cmp_idx]);
        rd_cmp = 0;
      end
      if (frame_err) begin
        ok = (ev_kind.size() > 0) && (ev_kind[0] == 1);
        chk("err_expected", ok, 1);
        if (ok) begin
          k = ev_kind.pop_front(); code = ev_code.pop_front();
          ecmd = ev_cmd.pop_front(); elen = ev_len.pop_front(); tchk = ev_tchk.pop_front();
          chk("err_code", err_code, code);
          if (tchk) chk("err_latency", cyc - last_strobe, 1);
        end
        if (frame_ready && prev_ready) begin
          chk("held_cmd", frame_cmd, held_cmd);
          chk("held_len", frame_len, held_len);
          reading = 1; rd_i = 0; frame_checked = 0;
        end
      end
      if (frame_ready && !prev_ready) begin
        ok = (ev_kind.size() > 0) && (ev_kind[0] == 0);
        chk("frame_expected", ok, 1);
        if (ok) begin
          k = ev_kind.pop_front(); code = ev_code.pop_front();
          ecmd = ev_cmd.pop_front(); elen = ev_len.pop_front(); tchk = ev_tchk.pop_front();
          chk("frame_cmd", frame_cmd, ecmd);
          chk("frame_len", frame_len, elen);
          chk("frame_latency", cyc - last_strobe, 1);
          for (int i = 0; i < int'(elen); i++) exp_pay[i] = pay_q.pop_front();
          held_cmd = ecmd; held_len = elen;
          rd_n = int'(elen); rd_i = 0; reading = 1; frame_checked = 0;
        end
      end
      if (reading) begin
        if (rd_i < rd_n) begin
          rd_addr = rd_i[ADDR_W-1:0];
          rd_cmp = 1; rd_cmp_idx = rd_i;
          rd_i++;
        end else begin
          reading = 0;
          frame_checked = 1;
        end
      end
      prev_ready = frame_ready;
    end
  end

  initial begin : stim
    int t;
    bit af;
    logic [7:0] b;
    rst_n = 1'b0; rx_data = 8'h00; rx_finish = 1'b0; frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // 55 AA 10 03 01 02 03 19, overrun 33, then ack together with 55 starting the next frame
    send_frame(8'h10, 3, 0, 0, 1'b0, 1'b1);
    wait_checked(); held = 1'b1;
    overrun(8'h33);
    send_frame(8'h10, 0, 0, 0, 1'b1, 1'b0);
    wait_checked(); held = 1'b1;
    ack_plain();

    // zero length good and bad checksum
    send_frame(8'h20, 0, 0, 0, 1'b0, 1'b0);
    wait_checked(); ack_plain();
    send_frame(8'h20, 0, 1, 0, 1'b0, 1'b0);

    // oversize length, then a valid frame at the length boundary
    send_frame(8'h10, 8'h11, 2, 0, 1'b0, 1'b0);
    send_frame(8'h5A, MAX_LEN, 0, 0, 1'b0, 1'b0);
    wait_checked(); ack_plain();
    send_frame(8'h01, 255, 2, 0, 1'b0, 1'b0);

    // resync on repeated header byte, then an aborted header
    send_frame(8'h10, 0, 0, 1, 1'b0, 1'b0);
    wait_checked(); ack_plain();
    send_byte(HDR0, 1'b0);
    send_byte(8'h12, 1'b0);
    repeat (4) @(negedge clk);

    for (int it = 0; it < 40; it++) begin
      t = $urandom_range(0, 4);
      af = 1'b0;
      if (held) begin
        if ($urandom_range(0, 2) == 0) overrun(8'($urandom_range(0, 255)));
        if (t <= 2 && $urandom_range(0, 1) == 1) begin
          af = 1'b1; held = 1'b0;
        end else begin
          ack_plain();
        end
      end
      case (t)
        0: begin
          send_frame(8'($urandom_range(0, 255)), $urandom_range(0, MAX_LEN), 0, 0, af, 1'b0);
          wait_checked(); held = 1'b1;
        end
        1: send_frame(8'($urandom_range(0, 255)), $urandom_range(0, MAX_LEN), 1, 0, af, 1'b0);
        2: send_frame(8'($urandom_range(0, 255)), $urandom_range(MAX_LEN + 1, 255), 2, 0, af, 1'b0);
        3: begin
          if ($urandom_range(0, 1) == 1) begin
            do b = 8'($urandom_range(0, 255)); while (b == HDR0);
            send_byte(b, 1'b0);
          end else begin
            send_byte(HDR0, 1'b0);
            do b = 8'($urandom_range(0, 255)); while (b == HDR0 || b == HDR1);
            send_byte(b, 1'b0);
          end
        end
        default: begin
          send_frame(8'($urandom_range(0, 255)), $urandom_range(0, MAX_LEN), 0,
                     $urandom_range(1, 3), 1'b0, 1'b0);
          wait_checked(); held = 1'b1;
        end
      endcase
    end
    if (held) ack_plain();

    // force a nonzero err_code, then reset in the middle of a payload
    send_frame(8'h10, 8'h11, 2, 0, 1'b0, 1'b0);
    send_byte(HDR0, 1'b0); send_byte(HDR1, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'h05, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("midreset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef FRAME_TIMEOUT_EN
    send_byte(HDR0, 1'b0); send_byte(HDR1, 1'b0);
    push_err(2'd2, 1'b0);
    send_byte(8'h10, 1'b0);
    for (int n = 0; n < 5000 && ev_kind.size() != 0; n++) @(negedge clk);
    chk("timeout_err_seen", ev_kind.size(), 0);
`endif

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", ev_kind.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
